// File: rtl/ds1302_sched.sv
// Scheduler in front of the DS1302 serial engine: power-up init write, then fixed-priority sharing
// between user writes, key reads and periodic reads, each transfer guarded by a watchdog.
module ds1302_sched #(
  parameter int unsigned PWRUP_CYC   = 1_000_000,
  parameter int unsigned RD_PERIOD   = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 200_000,
  parameter logic [87:0] INIT_DATA   = 88'h0023011015130101BE008E,
  parameter logic [87:0] RD_CMD      = 88'h00BF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_key,
  input  logic        wr_req,
  input  logic [87:0] wr_data,
  input  logic        opera_done,
  output logic        op_vld,
  output logic [87:0] op_dout,
  output logic        op_wr,
  output logic        wr_ack,
  output logic        rd_done,
  output logic        init_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [2:0]  o_dbg_state
);

  // Handshake: op_vld is a one-cycle start strobe; op_dout/op_wr stay stable until the
  // transfer is retired, and opera_done is only honoured while waiting on the engine.
  localparam int PW_W = (PWRUP_CYC   > 1) ? $clog2(PWRUP_CYC)   : 1;
  localparam int RP_W = (RD_PERIOD   > 1) ? $clog2(RD_PERIOD)   : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_INIT, K_UWR, K_RD} kind_t;

  state_t            r_state;
  kind_t             r_kind;
  logic [PW_W-1:0]   r_pw_cnt;
  logic [RP_W-1:0]   r_per_cnt;
  logic [TO_W-1:0]   r_wd;
  logic              r_key_pend, r_per_pend;
  logic              r_op_vld, r_op_wr, r_wr_ack, r_rd_done, r_init_done, r_busy, r_timeout;
  logic [87:0]       r_op_dout;

  logic              w_go, w_wr, w_pw_tc, w_wd_tc, w_wrap, w_rd_end;
  kind_t             w_kind;
  logic [87:0]       w_frame;

  assign w_pw_tc  = (r_pw_cnt == PW_W'(PWRUP_CYC - 1));
  assign w_wd_tc  = (r_wd == TO_W'(TIMEOUT_CYC - 1));
  assign w_wrap   = r_init_done && (r_per_cnt == RP_W'(RD_PERIOD - 1));
  assign w_rd_end = (r_state == S_WAIT) && (r_kind == K_RD) && (opera_done || w_wd_tc);

  always_comb begin
    w_go    = 1'b0;
    w_kind  = K_INIT;
    w_frame = INIT_DATA;
    w_wr    = 1'b0;
    if (r_state == S_PWRUP) begin
      w_go = w_pw_tc;
    end else if (r_state == S_IDLE) begin
      if (!r_init_done) begin
        w_go = 1'b1;
      end else if (wr_req) begin
        w_go    = 1'b1;
        w_kind  = K_UWR;
        w_frame = wr_data;
      end else if (r_key_pend || r_per_pend) begin
        w_go    = 1'b1;
        w_kind  = K_RD;
        w_frame = RD_CMD;
        w_wr    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWRUP;
      r_kind      <= K_INIT;
      r_pw_cnt    <= '0;
      r_per_cnt   <= '0;
      r_wd        <= '0;
      r_key_pend  <= 1'b0;
      r_per_pend  <= 1'b0;
      r_op_vld    <= 1'b0;
      r_op_dout   <= '0;
      r_op_wr     <= 1'b1;
      r_wr_ack    <= 1'b0;
      r_rd_done   <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_op_vld  <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rd_done <= 1'b0;
      r_timeout <= 1'b0;
      // A new request event on the retiring edge of a read survives the clear.
      r_key_pend <= rd_key || (r_key_pend && !w_rd_end);
      r_per_pend <= w_wrap || (r_per_pend && !w_rd_end);
      if (r_init_done)
        r_per_cnt <= w_wrap ? '0 : r_per_cnt + 1'b1;
      if (w_go) begin
        r_state   <= S_ISSUE;
        r_kind    <= w_kind;
        r_op_dout <= w_frame;
        r_op_wr   <= w_wr;
        r_op_vld  <= 1'b1;
        r_busy    <= 1'b1;
        r_pw_cnt  <= '0;
      end else begin
        case (r_state)
          S_PWRUP: r_pw_cnt <= r_pw_cnt + 1'b1;
          S_ISSUE: begin
            r_state <= S_WAIT;
            r_wd    <= '0;
          end
          S_WAIT: begin
            if (opera_done) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              case (r_kind)
                K_INIT:  r_init_done <= 1'b1;
                K_UWR:   r_wr_ack    <= 1'b1;
                default: r_rd_done   <= 1'b1;
              endcase
            end else if (w_wd_tc) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_timeout <= 1'b1;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign op_vld      = r_op_vld;
  assign op_dout     = r_op_dout;
  assign op_wr       = r_op_wr;
  assign wr_ack      = r_wr_ack;
  assign rd_done     = r_rd_done;
  assign init_done   = r_init_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ds1302_sched.sv
// Directed walk through init, key/user/periodic arbitration, watchdog and async reset,
// with randomized engine latencies and write frames; expected cycles derived from the timing rules.
module tb_ds1302_sched;

  localparam int PW = 100;
  localparam int RP = 500;
  localparam int TO = 50;
  localparam logic [87:0] INIT = 88'h0023011015130101BE008E;
  localparam logic [87:0] RDC  = 88'h00BF;

  logic        clk, rst_n, rd_key, wr_req, opera_done;
  logic [87:0] wr_data;
  logic        op_vld, op_wr, wr_ack, rd_done, init_done, busy, timeout_err;
  logic [87:0] op_dout;
  logic [2:0]  dbg_state;

  ds1302_sched #(.PWRUP_CYC(PW), .RD_PERIOD(RP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_key(rd_key), .wr_req(wr_req), .wr_data(wr_data),
    .opera_done(opera_done), .op_vld(op_vld), .op_dout(op_dout), .op_wr(op_wr),
    .wr_ack(wr_ack), .rd_done(rd_done), .init_done(init_done), .busy(busy),
    .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_vec, n_err, n_vld, n_rd, n_ack;
  always @(negedge clk)
    if (rst_n) begin
      if (op_vld)  n_vld++;
      if (rd_done) n_rd++;
      if (wr_ack)  n_ack++;
    end

  task chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task chk88(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task tick;
    @(negedge clk);
  endtask

  // returns the cycle op_vld is seen, or -1 if the budget runs out
  task wait_vld(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget && c < 0; i++) begin
      tick;
      if (op_vld) c = cyc;
    end
  endtask

  task wait_to(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget && c < 0; i++) begin
      tick;
      if (timeout_err) c = cyc;
    end
  endtask

  // Engine answers d cycles after op_vld; returns on the cycle the retire pulses are visible.
  task respond(input int d, input int key_at);
    for (int i = 1; i <= d; i++) begin
      tick;
      if (i == 1) begin
        chk1("vld_single_cycle", op_vld, 1'b0);
        chk1("busy_in_wait", busy, 1'b1);
      end
      rd_key = (i == key_at);
    end
    rd_key = 1'b0;
    opera_done = 1'b1;
    tick;
    opera_done = 1'b0;
  endtask

  function automatic logic [87:0] rand_frame();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[87:0];
  endfunction

  initial begin
    int c, c2, t, e, d_init, base;
    logic [87:0] frame;
    n_vec = 0; n_err = 0; n_vld = 0; n_rd = 0; n_ack = 0;
    clk = 0; rst_n = 0; rd_key = 0; wr_req = 0; opera_done = 0; wr_data = '0;

    repeat (3) tick;
    chk1("rst_op_vld", op_vld, 1'b0);
    chk88("rst_op_dout", op_dout, 88'h0);
    chk1("rst_op_wr", op_wr, 1'b1);
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_pulses", wr_ack | rd_done | timeout_err, 1'b0);
    rst_n = 1;

    // key during power-up is latched; init write goes out PW cycles after release
    while (cyc < 19) tick;
    rd_key = 1; tick; rd_key = 0;
    wait_vld(300, c);
    chki("init_vld_cycle", c, PW);
    chk88("init_frame", op_dout, INIT);
    chk1("init_op_wr", op_wr, 1'b0);
    chk1("init_busy", busy, 1'b1);
    respond(10, 0);
    chk1("init_done_set", init_done, 1'b1);
    chk1("init_no_rd_done", rd_done, 1'b0);
    chk1("done_not_busy", busy, 1'b0);
    d_init = cyc;

    // latched key read follows: DONE, IDLE, then ISSUE
    wait_vld(20, c);
    chki("key_rd_cycle", c, d_init + 2);
    chk88("key_rd_frame", op_dout, RDC);
    chk1("key_rd_op_wr", op_wr, 1'b1);
    respond($urandom_range(1, 30), 0);
    chk1("key_rd_done", rd_done, 1'b1);
    tick;
    chk1("rd_done_single", rd_done, 1'b0);

    // stray opera_done in IDLE, then user write and key in the same cycle
    repeat ($urandom_range(2, 8)) tick;
    opera_done = 1; tick; opera_done = 0; tick;
    chk1("stray_done_idle", busy | op_vld | wr_ack | rd_done, 1'b0);
    base = n_vld;
    frame = rand_frame();
    wr_req = 1; wr_data = frame; rd_key = 1;
    tick;
    rd_key = 0;
    chk1("uwr_vld", op_vld, 1'b1);
    chk88("uwr_frame", op_dout, frame);
    chk1("uwr_op_wr", op_wr, 1'b0);
    respond($urandom_range(1, 30), 0);
    chk1("uwr_ack", wr_ack, 1'b1);
    wr_req = 0;
    e = cyc;
    wait_vld(20, c);
    chki("after_uwr_rd_cycle", c, e + 2);
    chk88("after_uwr_rd_frame", op_dout, RDC);
    respond($urandom_range(1, 30), 0);
    chk1("after_uwr_rd_done", rd_done, 1'b1);
    tick;
    chki("two_ops_issued", n_vld - base, 2);

    // periodic reads; a key during the first one coalesces into it
    base = n_rd;
    wait_vld(600, c);
    chki("per1_cycle", c, d_init + RP + 1);
    chk88("per1_frame", op_dout, RDC);
    respond($urandom_range(5, 30), 2);
    chk1("per1_rd_done", rd_done, 1'b1);
    wait_vld(600, c);
    chki("per2_cycle_no_extra_op", c, d_init + 2 * RP + 1);
    respond($urandom_range(1, 30), 0);
    wait_vld(600, c);
    chki("per3_cycle", c, d_init + 3 * RP + 1);
    respond($urandom_range(1, 30), 0);
    tick;
    chki("three_rd_done", n_rd - base, 3);

    // read timeout: pulse after TO wait cycles, no rd_done, pending dropped
    base = n_rd;
    wait_vld(600, c);
    chki("per4_cycle", c, d_init + 4 * RP + 1);
    wait_to(100, t);
    chki("rd_timeout_cycle", t, c + TO + 1);
    chk1("rd_timeout_not_busy", busy, 1'b0);
    chki("rd_timeout_no_done", n_rd - base, 0);

    // user write timeout, retried while wr_req held, acked on later success
    base = n_ack;
    repeat ($urandom_range(2, 5)) tick;
    frame = rand_frame();
    wr_req = 1; wr_data = frame;
    tick;
    chk1("uwr2_vld", op_vld, 1'b1);
    c = cyc;
    wait_to(100, t);
    chki("uwr_timeout_cycle", t, c + TO + 1);
    chk1("uwr_timeout_no_ack", wr_ack, 1'b0);
    wait_vld(10, c2);
    chki("uwr_retry_cycle", c2, c + TO + 3);
    chk88("uwr_retry_frame", op_dout, frame);
    respond($urandom_range(1, 30), 0);
    chk1("uwr_retry_ack", wr_ack, 1'b1);
    wr_req = 0;
    tick;
    chki("uwr_single_ack", n_ack - base, 1);
    wait_vld(600, c);
    chki("per5_cycle", c, d_init + 5 * RP + 1);
    chk88("per5_frame", op_dout, RDC);

    // asynchronous reset mid-transfer
    repeat (5) tick;
    chk1("busy_before_reset", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk88("arst_op_dout", op_dout, 88'h0);
    chk1("arst_op_wr", op_wr, 1'b1);
    chk1("arst_init_done", init_done, 1'b0);
    chk1("arst_pulses", op_vld | wr_ack | rd_done | timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1;
    wait_vld(300, c);
    chki("reinit_vld_cycle", c, PW);
    chk88("reinit_frame", op_dout, INIT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
